// File: rtl/systolic_feeder.sv
// Operand loader and lane streamer for the 3x3 output-stationary array.
// Captures A/B, clears the array, streams k=0..2, drains, then pulses done.
module systolic_feeder #(
  parameter int DATA_SIZE = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [9*DATA_SIZE-1:0] load_a,
  input  logic [9*DATA_SIZE-1:0] load_b,
  output logic [3*DATA_SIZE-1:0] matrix_a_out,
  output logic [3*DATA_SIZE-1:0] matrix_b_out,
  output logic                   valid_out,
  output logic                   array_clear,
  output logic                   busy,
  output logic                   done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]             state;
  logic [1:0]             cnt;
  logic [1:0]             k_nxt;
  logic [9*DATA_SIZE-1:0] a_reg;
  logic [9*DATA_SIZE-1:0] b_reg;
  logic [3*DATA_SIZE-1:0] a_col;
  logic [3*DATA_SIZE-1:0] b_col;

  // Lanes are registered, so select the column/row for the step being entered.
  always_comb begin
    k_nxt = 2'd0;
    if (state == S_STREAM && cnt != 2'd2)
      k_nxt = cnt + 2'd1;
    a_col = '0;
    b_col = '0;
    for (int i = 0; i < 3; i++) begin
      a_col[i*DATA_SIZE +: DATA_SIZE] =
        a_reg[(3*i + int'(k_nxt))*DATA_SIZE +: DATA_SIZE];
      b_col[i*DATA_SIZE +: DATA_SIZE] =
        b_reg[(3*int'(k_nxt) + i)*DATA_SIZE +: DATA_SIZE];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= 2'd0;
      a_reg        <= '0;
      b_reg        <= '0;
      load_ready   <= 1'b1;
      array_clear  <= 1'b1;
      matrix_a_out <= '0;
      matrix_b_out <= '0;
      valid_out    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      array_clear  <= 1'b0;
      done         <= 1'b0;
      valid_out    <= 1'b0;
      matrix_a_out <= '0;
      matrix_b_out <= '0;
      unique case (state)
        S_IDLE: begin
          if (load_valid && load_ready) begin
            a_reg       <= load_a;
            b_reg       <= load_b;
            state       <= S_CLEAR;
            load_ready  <= 1'b0;
            busy        <= 1'b1;
            array_clear <= 1'b1;
          end
        end
        S_CLEAR: begin
          state        <= S_STREAM;
          cnt          <= 2'd0;
          valid_out    <= 1'b1;
          matrix_a_out <= a_col;
          matrix_b_out <= b_col;
        end
        S_STREAM: begin
          if (cnt == 2'd2) begin
            state <= S_DRAIN;
            cnt   <= 2'd0;
          end else begin
            cnt          <= cnt + 2'd1;
            valid_out    <= 1'b1;
            matrix_a_out <= a_col;
            matrix_b_out <= b_col;
          end
        end
        S_DRAIN: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          load_ready <= 1'b1;
        end
        default: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized scoreboard bench for systolic_feeder.
// Accepted jobs are queued; a negedge monitor checks every cycle against them.
module tb_systolic_feeder;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [9*W-1:0] load_a = '0;
  logic [9*W-1:0] load_b = '0;
  logic [3*W-1:0] matrix_a_out;
  logic [3*W-1:0] matrix_b_out;
  logic          valid_out;
  logic          array_clear;
  logic          busy;
  logic          done;

  systolic_feeder #(.DATA_SIZE(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_a       (load_a),
    .load_b       (load_b),
    .matrix_a_out (matrix_a_out),
    .matrix_b_out (matrix_b_out),
    .valid_out    (valid_out),
    .array_clear  (array_clear),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_acc = 0;
  int last_acc = 0;

  logic [9*W-1:0] qa[$];
  logic [9*W-1:0] qb[$];
  int             qt[$];

  int c_obs[3][3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int el(input logic [9*W-1:0] m, input int i,
                            input int j);
    return int'(m[(3*i+j)*W +: W]);
  endfunction

  function automatic logic [9*W-1:0] rnd72();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[9*W-1:0];
  endfunction

  // C = A x B modulo the array's 17-bit accumulator width
  function automatic int ref_c(input logic [9*W-1:0] a,
                               input logic [9*W-1:0] b, input int i,
                               input int j);
    int s;
    s = 0;
    for (int k = 0; k < 3; k++) s += el(a, i, k) * el(b, k, j);
    return s & 32'h1ffff;
  endfunction

  // Expected cycle behaviour by offset from acceptance (1 = clear cycle)
  always @(negedge clk) begin
    int rel;
    logic [4:0] ectl;
    logic [6*W-1:0] elan;
    if (reset) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) c_obs[i][j] = 0;
    end else begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          if (array_clear) c_obs[i][j] = 0;
          else if (valid_out)
            c_obs[i][j] = (c_obs[i][j]
              + int'(matrix_a_out[i*W +: W]) * int'(matrix_b_out[j*W +: W]))
              & 32'h1ffff;
      rel = (qt.size() != 0) ? cyc - qt[0] + 1 : 0;
      elan = '0;
      if (rel == 1) ectl = 5'b01001;
      else if (rel >= 2 && rel <= 4) begin
        ectl = 5'b01100;
        for (int i = 0; i < 3; i++) begin
          elan[(3+i)*W +: W] = W'(el(qa[0], i, rel-2));
          elan[i*W +: W]     = W'(el(qb[0], rel-2, i));
        end
      end
      else if (rel >= 5 && rel <= 8) ectl = 5'b01000;
      else if (rel == 9) ectl = 5'b01010;
      else ectl = 5'b10000;
      chk("ctrl{ready,busy,valid,done,clear}",
          64'({load_ready, busy, valid_out, done, array_clear}), 64'(ectl));
      chk("lanes{a,b}", 64'({matrix_a_out, matrix_b_out}), 64'(elan));
      if (rel == 9) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            chk($sformatf("c[%0d][%0d]", i, j), 64'(c_obs[i][j]),
                64'(ref_c(qa[0], qb[0], i, j)));
        void'(qa.pop_front());
        void'(qb.pop_front());
        void'(qt.pop_front());
      end
    end
  end

  task automatic drive(input logic v, input logic [9*W-1:0] a,
                       input logic [9*W-1:0] b);
    @(negedge clk);
    load_valid = v;
    load_a = a;
    load_b = b;
    #1;
    if (v && load_ready && !reset) begin
      qa.push_back(a);
      qb.push_back(b);
      qt.push_back(cyc + 1);
      last_acc = cyc + 1;
      n_acc++;
    end
  endtask

  task automatic load(input logic [9*W-1:0] a, input logic [9*W-1:0] b);
    drive(1'b1, a, b);
    drive(1'b0, rnd72(), rnd72());
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (qt.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("job_timeout_pending", 64'(qt.size()), 64'd0);
  endtask

  task automatic chk_reset_vals();
    chk("reset_ctrl", 64'({load_ready, busy, valid_out, done, array_clear}),
        64'(5'b10001));
    chk("reset_lanes", 64'({matrix_a_out, matrix_b_out}), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9*W-1:0] mi, mb, mn;
    int sq[9];
    sq = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
    mi = '0;
    mb = '0;
    for (int x = 0; x < 9; x++) mb[x*W +: W] = W'(x + 1);
    for (int x = 0; x < 3; x++) mi[4*x*W +: W] = W'(1);

    #1 reset = 1'b1;
    #1 chk_reset_vals();
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    repeat (6) drive(1'b0, '0, '0);

    load(mi, mb);
    wait_done();
    #1;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        chk("identity_c", 64'(c_obs[i][j]), 64'(3*i + j + 1));

    load(mb, mb);
    wait_done();
    repeat (11) @(negedge clk);
    #1;
    for (int x = 0; x < 9; x++)
      chk("square_c_stable", 64'(c_obs[x/3][x%3]), 64'(sq[x]));

    n_acc = 0;
    for (int x = 0; x < 25; x++) drive(1'b1, rnd72(), rnd72());
    drive(1'b0, '0, '0);
    chk("held_valid_accepts", 64'(n_acc), 64'd3);
    wait_done();

    mn = rnd72();
    load(mn, rnd72());
    drive(1'b1, rnd72(), rnd72());
    drive(1'b1, rnd72(), rnd72());
    drive(1'b0, '0, '0);
    wait_done();

    load(rnd72(), rnd72());
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 chk_reset_vals();
    qa.delete();
    qb.delete();
    qt.delete();
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    repeat (12) drive(1'b0, '0, '0);
    load(rnd72(), rnd72());
    wait_done();

    for (int t = 0; t < 15; t++) begin
      repeat ($urandom_range(0, 3)) drive(1'b0, rnd72(), rnd72());
      load(rnd72(), rnd72());
      repeat ($urandom_range(0, 6))
        drive(1'($urandom_range(0, 1)), rnd72(), rnd72());
      drive(1'b0, '0, '0);
      wait_done();
    end
    repeat (3) drive(1'b0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
